roberts_cross_sched: RTL and testbench

//  Sequencer for one Roberts-cross core. Accepts 2x2 pixel windows on a valid/ready input,

---
 rtl/rc_sched_pkg.sv | 33 +++
 rtl/rc_sched_cycle_counter.sv | 36 +++
 rtl/roberts_cross_sched.sv | 167 ++++++++++++++++
 tb/tb_roberts_cross_sched.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc_sched_pkg.sv
// Shared types and constants for the Roberts-cross sequencer.
// rc_expected is the golden window result, used by the bench to predict
// what the core returns.
package rc_sched_pkg;

  localparam int RC_DATA_WIDTH = 8;
  localparam int RC_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } rc_state_t;

  // |a00-a11| + |a01-a10|, clipped to the largest pixel value
  function automatic logic [RC_DATA_WIDTH-1:0] rc_expected(
    input logic [RC_DATA_WIDTH-1:0] a00,
    input logic [RC_DATA_WIDTH-1:0] a01,
    input logic [RC_DATA_WIDTH-1:0] a10,
    input logic [RC_DATA_WIDTH-1:0] a11
  );
    int d0;
    int d1;
    int s;
    d0 = (a00 > a11) ? (int'(a00) - int'(a11)) : (int'(a11) - int'(a00));
    d1 = (a01 > a10) ? (int'(a01) - int'(a10)) : (int'(a10) - int'(a01));
    s  = d0 + d1;
    if (s > (2**RC_DATA_WIDTH) - 1) s = (2**RC_DATA_WIDTH) - 1;
    return RC_DATA_WIDTH'(s);
  endfunction

endpackage

// File: rtl/rc_sched_cycle_counter.sv
// Saturating RUN-cycle counter with synchronous clear.
// Once it reaches all-ones it holds there and raises sat_o.
module rc_sched_cycle_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 en_i,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 sat_o
);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  assign sat_o   = &count_q;
  assign count_o = count_q;

  // Next count: clear wins, otherwise step while enabled and not saturated
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !sat_o) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/roberts_cross_sched.sv
// Sequencer for one Roberts-cross core: accept window, LOAD (core held in
// reset for one cycle), RUN with core_en until op_finished / budget /
// counter saturation, then present result until consumed.
// Handshakes: a transfer happens on a rising edge where valid && ready;
// in_ready is high only in IDLE, out_valid holds its payload stable until
// out_ready is seen.
// Optional feature macro: RC_SCHED_STATS_EN adds stat_ops/stat_cycles/stat_trunc.
module roberts_cross_sched
  import rc_sched_pkg::*;
#(
  parameter int DATA_WIDTH = RC_DATA_WIDTH,
  parameter int CNT_WIDTH  = RC_CNT_WIDTH
) (
  input  logic                  gclk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_px00,
  input  logic [DATA_WIDTH-1:0] in_px01,
  input  logic [DATA_WIDTH-1:0] in_px10,
  input  logic [DATA_WIDTH-1:0] in_px11,
  input  logic [CNT_WIDTH-1:0]  cycle_budget,
  output logic                  core_rst,
  output logic                  core_en,
  output logic [DATA_WIDTH-1:0] core_in00,
  output logic [DATA_WIDTH-1:0] core_in01,
  output logic [DATA_WIDTH-1:0] core_in10,
  output logic [DATA_WIDTH-1:0] core_in11,
  input  logic [DATA_WIDTH-1:0] core_data_out,
  input  logic                  core_op_finished,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  out_cycles,
  output logic                  out_truncated,
  output logic                  busy,
  output rc_state_t             dbg_state
`ifdef RC_SCHED_STATS_EN
  ,
  output logic [31:0]           stat_ops,
  output logic [31:0]           stat_cycles,
  output logic [31:0]           stat_trunc
`endif
);

  rc_state_t             state_q;
  logic                  core_rst_q;
  logic                  core_en_q;
  logic [DATA_WIDTH-1:0] in00_q, in01_q, in10_q, in11_q;
  logic [CNT_WIDTH-1:0]  budget_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [CNT_WIDTH-1:0]  out_cycles_q;
  logic                  out_trunc_q;

  logic [CNT_WIDTH-1:0]  count;
  logic                  count_sat;
  logic                  run_exit;

  // Counter is zero through LOAD and reads 1 in the first RUN cycle
  rc_sched_cycle_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
    .clk     (gclk),
    .rst_n   (rst_n),
    .clr_i   (state_q == IDLE),
    .en_i    ((state_q == LOAD) || (state_q == RUN)),
    .count_o (count),
    .sat_o   (count_sat)
  );

  assign run_exit = core_op_finished
                 || ((budget_q != '0) && (count == budget_q))
                 || count_sat;

  assign in_ready      = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign dbg_state     = state_q;
  assign core_rst      = core_rst_q;
  assign core_en       = core_en_q;
  assign core_in00     = in00_q;
  assign core_in01     = in01_q;
  assign core_in10     = in10_q;
  assign core_in11     = in11_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_cycles    = out_cycles_q;
  assign out_truncated = out_trunc_q;

  // Sequencer FSM with registered core controls and result registers
  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      core_rst_q   <= 1'b1;
      core_en_q    <= 1'b0;
      in00_q       <= '0;
      in01_q       <= '0;
      in10_q       <= '0;
      in11_q       <= '0;
      budget_q     <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_cycles_q <= '0;
      out_trunc_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            in00_q   <= in_px00;
            in01_q   <= in_px01;
            in10_q   <= in_px10;
            in11_q   <= in_px11;
            budget_q <= cycle_budget;
            state_q  <= LOAD;
          end
        end
        LOAD: begin
          core_rst_q <= 1'b0;
          core_en_q  <= 1'b1;
          state_q    <= RUN;
        end
        RUN: begin
          if (run_exit) begin
            out_data_q   <= core_data_out;
            out_cycles_q <= count;
            out_trunc_q  <= !core_op_finished;
            out_valid_q  <= 1'b1;
            core_en_q    <= 1'b0;
            core_rst_q   <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef RC_SCHED_STATS_EN
  logic [31:0] stat_ops_q;
  logic [31:0] stat_cycles_q;
  logic [31:0] stat_trunc_q;
  logic [32:0] cyc_sum;

  assign cyc_sum     = {1'b0, stat_cycles_q} + 33'(out_cycles_q);
  assign stat_ops    = stat_ops_q;
  assign stat_cycles = stat_cycles_q;
  assign stat_trunc  = stat_trunc_q;

  // Saturating statistics, updated on each output handshake
  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops_q    <= '0;
      stat_cycles_q <= '0;
      stat_trunc_q  <= '0;
    end else if (out_valid_q && out_ready) begin
      if (!(&stat_ops_q)) stat_ops_q <= stat_ops_q + 32'd1;
      stat_cycles_q <= cyc_sum[32] ? '1 : cyc_sum[31:0];
      if (out_trunc_q && !(&stat_trunc_q)) stat_trunc_q <= stat_trunc_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_roberts_cross_sched.sv
// Bench for roberts_cross_sched. The core is a behavioural stand-in whose
// latency (enabled cycles before op_finished) is set per operation; its
// result is rc_expected of the operands it was handed.
module tb_roberts_cross_sched;
  import rc_sched_pkg::*;

  localparam int DW = 8;
  localparam int CW = 16;

  typedef struct {
    logic [DW-1:0] p00, p01, p10, p11;
    logic [CW-1:0] bud;
    int            lat;
    logic [DW-1:0] exp_data;
    logic [CW-1:0] exp_cycles;
    logic          exp_trunc;
  } vec_t;

  logic          gclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_px00 = '0, in_px01 = '0, in_px10 = '0, in_px11 = '0;
  logic [CW-1:0] cycle_budget = '0;
  logic          core_rst, core_en;
  logic [DW-1:0] core_in00, core_in01, core_in10, core_in11;
  logic [DW-1:0] core_data_out;
  logic          core_op_finished;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_cycles;
  logic          out_truncated;
  logic          busy;
  rc_state_t     dbg_state;
`ifdef RC_SCHED_STATS_EN
  logic [31:0]   stat_ops, stat_cycles, stat_trunc;
`endif

  int checks = 0;
  int failures = 0;
  logic [DW+CW:0] exp_q[$];

  // ---------------- clock / reset / watchdog ----------------
  always #5 gclk = ~gclk;

  initial begin
    repeat (100000) @(posedge gclk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural core ----------------
  int            core_lat = 1;
  logic [CW-1:0] core_cnt_q;

  always @(posedge gclk or negedge rst_n) begin
    if (!rst_n)        core_cnt_q <= '0;
    else if (core_rst) core_cnt_q <= '0;
    else if (core_en)  core_cnt_q <= core_cnt_q + 16'd1;
  end

  assign core_op_finished = !core_rst && (int'(core_cnt_q) >= core_lat);
  assign core_data_out    = rc_expected(core_in00, core_in01, core_in10, core_in11);

  roberts_cross_sched #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .gclk             (gclk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_px00          (in_px00),
    .in_px01          (in_px01),
    .in_px10          (in_px10),
    .in_px11          (in_px11),
    .cycle_budget     (cycle_budget),
    .core_rst         (core_rst),
    .core_en          (core_en),
    .core_in00        (core_in00),
    .core_in01        (core_in01),
    .core_in10        (core_in10),
    .core_in11        (core_in11),
    .core_data_out    (core_data_out),
    .core_op_finished (core_op_finished),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_cycles       (out_cycles),
    .out_truncated    (out_truncated),
    .busy             (busy),
    .dbg_state        (dbg_state)
`ifdef RC_SCHED_STATS_EN
    ,
    .stat_ops         (stat_ops),
    .stat_cycles      (stat_cycles),
    .stat_trunc       (stat_trunc)
`endif
  );

  // ---------------- checker ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: cycles run = core latency + 1 (finish seen one
  // cycle after the last counted enable), cut short by a nonzero budget.
  function automatic logic [DW+CW:0] model(input vec_t v);
    int cyc;
    logic tr;
    cyc = v.lat + 1;
    tr  = 1'b0;
    if (v.bud != 0 && int'(v.bud) < cyc) begin
      cyc = int'(v.bud);
      tr  = 1'b1;
    end
    return {rc_expected(v.p00, v.p01, v.p10, v.p11), CW'(cyc), tr};
  endfunction

  // ---------------- driver: one full operation ----------------
  // Entered and left on a negedge. While stalling the output, optionally
  // presents the next window to show it is refused until IDLE.
  task automatic do_op(input vec_t v, input int stall, input bit show_nxt,
                       input vec_t nxt, output int acc_wait);
    int n, en_seen, load_seen;
    logic [DW+CW:0] exp;
    logic [DW-1:0]  hd;
    logic [CW-1:0]  hc;
    logic           ht;
    core_lat     = v.lat;
    in_px00      = v.p00;
    in_px01      = v.p01;
    in_px10      = v.p10;
    in_px11      = v.p11;
    cycle_budget = v.bud;
    in_valid     = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge gclk);
      n++;
    end
    acc_wait = n;
    if (!in_ready) chk("accept_timeout", 32'(n), 32'd0);
    @(negedge gclk);
    in_valid = 1'b0;
    en_seen = 0;
    load_seen = 0;
    n = 0;
    while (!out_valid && n < 70000) begin
      if (core_en) en_seen++;
      if (busy && core_rst && !core_en) load_seen++;
      @(negedge gclk);
      n++;
    end
    chk("out_valid_seen", 32'(out_valid), 32'd1);
    hd = out_data;
    hc = out_cycles;
    ht = out_truncated;
    if (show_nxt) begin
      in_px00 = nxt.p00; in_px01 = nxt.p01; in_px10 = nxt.p10; in_px11 = nxt.p11;
      cycle_budget = nxt.bud;
      in_valid = 1'b1;
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge gclk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'(out_data), 32'(hd));
      chk("hold_cycles", 32'(out_cycles), 32'(hc));
      chk("hold_trunc", 32'(out_truncated), 32'(ht));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge gclk);
    out_ready = 1'b0;
    chk("valid_drop", 32'(out_valid), 32'd0);
    chk("back_idle_ready", 32'(in_ready), 32'd1);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      exp = exp_q.pop_front();
      chk("out_data", 32'(hd), 32'(exp[DW+CW:CW+1]));
      chk("out_cycles", 32'(hc), 32'(exp[CW:1]));
      chk("out_truncated", 32'(ht), 32'(exp[0]));
      chk("en_cycles", 32'(en_seen), 32'(exp[CW:1]));
      chk("load_cycles", 32'(load_seen), 32'd1);
    end
  endtask

  // ---------------- test sequence ----------------
  vec_t tbl[5];
  vec_t v, none;
  int   w;

  initial begin
    tbl[0] = '{200, 50, 30, 10, 16'd0, 5, 8'd210, 16'd6, 1'b0};
    tbl[1] = '{255, 255, 0, 0, 16'd0, 3, 8'd255, 16'd4, 1'b0};
    tbl[2] = '{200, 50, 30, 10, 16'd4, 5, 8'd210, 16'd4, 1'b1};
    tbl[3] = '{10, 20, 30, 40, 16'd6, 5, 8'd40, 16'd6, 1'b0};
    tbl[4] = '{100, 0, 0, 100, 16'd1, 5, 8'd0, 16'd1, 1'b1};
    none   = '{0, 0, 0, 0, 16'd0, 1, 8'd0, 16'd0, 1'b0};

    // reset state
    repeat (3) @(negedge gclk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_core_en", 32'(core_en), 32'd0);
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge gclk);

    // directed table
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({tbl[i].exp_data, tbl[i].exp_cycles, tbl[i].exp_trunc});
      do_op(tbl[i], 0, 1'b0, none, w);
      if (i == 0) chk("first_accept_wait", 32'(w), 32'd0);
      chk("core_in_hold", 32'(core_in00), 32'(tbl[i].p00));
`ifdef RC_SCHED_STATS_EN
      if (i == 2) begin
        chk("stat_ops", stat_ops, 32'd3);
        chk("stat_trunc", stat_trunc, 32'd1);
        chk("stat_cycles", stat_cycles, 32'd14);
      end
`endif
    end

    // output stall with a second window waiting
    exp_q.push_back({tbl[1].exp_data, tbl[1].exp_cycles, tbl[1].exp_trunc});
    do_op(tbl[1], 10, 1'b1, tbl[3], w);
    exp_q.push_back({tbl[3].exp_data, tbl[3].exp_cycles, tbl[3].exp_trunc});
    do_op(tbl[3], 0, 1'b0, none, w);
    chk("second_accept_wait", 32'(w), 32'd0);

    // randomized operations against the model
    for (int i = 0; i < 25; i++) begin
      v.p00 = DW'($urandom_range(0, 255));
      v.p01 = DW'($urandom_range(0, 255));
      v.p10 = DW'($urandom_range(0, 255));
      v.p11 = DW'($urandom_range(0, 255));
      v.bud = ($urandom_range(0, 2) == 0) ? 16'd0 : CW'($urandom_range(1, 10));
      v.lat = $urandom_range(1, 10);
      exp_q.push_back(model(v));
      do_op(v, $urandom_range(0, 3), 1'b0, none, w);
      repeat ($urandom_range(0, 2)) @(negedge gclk);
    end

    // asynchronous abort mid-RUN
    core_lat = 30;
    in_px00 = 8'd1; in_px01 = 8'd2; in_px10 = 8'd3; in_px11 = 8'd4;
    cycle_budget = 16'd0;
    in_valid = 1'b1;
    @(negedge gclk);
    in_valid = 1'b0;
    repeat (5) @(negedge gclk);
    chk("abort_pre_en", 32'(core_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_core_en", 32'(core_en), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_core_rst", 32'(core_rst), 32'd1);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    @(negedge gclk);
    rst_n = 1'b1;
    @(negedge gclk);
    exp_q.push_back({8'd210, 16'd6, 1'b0});
    do_op(tbl[0], 0, 1'b0, none, w);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
